// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO and its storage.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 8;

    typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Register-array storage: synchronous write port, registered read port.
// Read data resets to zero; the array itself is never cleared.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming word; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; output holds when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : fifo_mem

// File: rtl/fifo.sv
// Single-clock synchronous FIFO with occupancy-counter flags and a
// board LED that mirrors the full flag.
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  led
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags come straight from the registered count; a read freeing a slot
    // lets a write into a full FIFO in the same cycle.
    always_comb begin
        full  = (count == CNT_WIDTH'(DEPTH));
        empty = (count == '0);
        led   = full;
        rd_ok = rd_en && !empty;
        wr_ok = wr_en && (!full || rd_ok);
    end

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CNT_WIDTH'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule : fifo

// File: tb/tb_fifo.sv
// Directed and randomized bench for the synchronous FIFO, checked against
// a queue-based reference model.
module tb_fifo;
    import fifo_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    fifo_word_t data_in = '0;
    fifo_word_t data_out;
    logic       full;
    logic       empty;
    logic       led;

    int compared   = 0;
    int mismatched = 0;

    fifo_word_t model_q [$];
    fifo_word_t exp_dout = '0;

    fifo #(
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .led      (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
        check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
        check({tag, ".led"}, 32'(led), 32'(model_q.size() == DEPTH));
    endtask

    // One clock with the given request; the model applies the FIFO rules.
    task automatic step(input logic we, input logic re, input fifo_word_t din, input string tag);
        bit rd_ok;
        bit wr_ok;
        wr_en   = we;
        rd_en   = re;
        data_in = din;
        @(posedge clk);
        rd_ok = re && (model_q.size() > 0);
        wr_ok = we && ((model_q.size() < DEPTH) || rd_ok);
        if (rd_ok) exp_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(din);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input int cycles, input string tag);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_q.delete();
        exp_dout = '0;
        check_all(tag);
    endtask

    initial begin
        // Reset held for two cycles, with requests active to show override.
        wr_en = 1'b1;
        rd_en = 1'b1;
        data_in = 8'hEE;
        do_reset(2, "reset");

        // Fill with 0x11..0x88.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, fifo_word_t'(i * 8'h11), "fill");
        end
        check("fill.full_now", 32'(full), 32'd1);

        // Overflow attempt is dropped.
        step(1'b1, 1'b0, 8'h99, "overflow");

        // Drain, then one extra read on empty.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00, "drain");
            check("drain.value", 32'(data_out), 32'(i * 8'h11));
        end
        step(1'b0, 1'b1, 8'h00, "read_empty");
        check("read_empty.hold", 32'(data_out), 32'h88);

        // Simultaneous read/write at count 4.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, fifo_word_t'(8'hA0 + i), "to4");
        step(1'b1, 1'b1, 8'hB0, "rw_at4");
        check("rw_at4.oldest", 32'(data_out), 32'hA0);
        check("rw_at4.count", 32'(model_q.size()), 32'd4);

        // Simultaneous read/write at empty.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, "to0");
        step(1'b1, 1'b1, 8'h5A, "rw_empty");
        check("rw_empty.not_empty", 32'(empty), 32'd0);
        check("rw_empty.dout_hold", 32'(data_out), 32'hB0);

        // Simultaneous read/write at full.
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, fifo_word_t'(8'hC0 + i), "to_full");
        step(1'b1, 1'b1, 8'hD0, "rw_full");
        check("rw_full.full", 32'(full), 32'd1);
        check("rw_full.dout", 32'(data_out), 32'h5A);

        // Wrap: 12 writes interleaved with reads.
        do_reset(1, "pre_wrap");
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, fifo_word_t'(8'h30 + i), "wrap_w");
            if (i % 2 == 1) step(1'b0, 1'b1, 8'h00, "wrap_r");
        end
        while (model_q.size() > 0) step(1'b0, 1'b1, 8'h00, "wrap_drain");
        check("wrap.last", 32'(data_out), 32'h3B);

        // Mid-operation reset at count 3 discards data.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, fifo_word_t'(8'h70 + i), "pre_rst");
        do_reset(1, "mid_reset");
        step(1'b0, 1'b1, 8'h00, "post_rst_read");
        step(1'b0, 1'b1, 8'h00, "post_rst_read2");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset(1, "rand_reset");
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     fifo_word_t'($urandom), "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_fifo
